// File: rtl/adder_measure_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_measure_pkg
// Description : Shared types and constants for the Brent-Kung adder
//               ring-oscillator measurement sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_measure_pkg;

    localparam int DEF_COUNT_W       = 32;
    localparam int DEF_GATE_W        = 16;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Path codes presented on path_sel
    localparam logic [1:0] PATH_A_RING = 2'd0;
    localparam logic [1:0] PATH_A_EXT  = 2'd1;
    localparam logic [1:0] PATH_S_OUT  = 2'd2;
    localparam logic [1:0] PATH_RSVD   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // One-hot select of a single adder bit
    function automatic logic [31:0] onehot32(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : ring_edge_sync
// Description : Two-flop synchronizer for the asynchronous ring oscillator
//               output plus a third flop for rising-edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ring_in,
    output logic rise
);

    logic q1;
    logic q2;
    logic q3;

    // Synchronizer chain; q3 holds the previous synchronized value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= ring_in;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign rise = q2 & ~q3;

endmodule
`default_nettype wire

// File: rtl/adder_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_measure_ctrl
// Description : Selects an adder bit/path, enables the ring oscillator, lets
//               it settle, counts synchronized chain_out rising edges over a
//               programmable gate window and reports the result.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_measure_ctrl
    import adder_measure_pkg::*;
#(
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic [1:0]         path_sel,
    input  logic [4:0]         bit_sel,
    input  logic               ring_in,
    output logic               ring_en,
    output logic [31:0]        a_ring_mask,
    output logic [31:0]        a_ext_mask,
    output logic [31:0]        s_out_mask,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic               err
);

    localparam int ST_W = $clog2(SETTLE_CYCLES);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                reject;
    logic                rise;
    logic [GATE_W-1:0]   gate_q;
    logic [1:0]          path_q;
    logic [4:0]          bit_q;
    logic [GATE_W-1:0]   gate_cnt;
    logic [ST_W-1:0]     settle_cnt;
    logic [1:0]          sel_path;
    logic [4:0]          sel_bit;
    logic [31:0]         a_ring_nxt;
    logic [31:0]         a_ext_nxt;
    logic [31:0]         s_out_nxt;

    ring_edge_sync u_sync (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .ring_in (ring_in),
        .rise    (rise)
    );

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and request qualification
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (path_sel == PATH_RSVD || gate_len == '0) begin
                        reject    = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP:   state_nxt = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == '0) state_nxt = ST_MEASURE;
            ST_MEASURE: if (gate_cnt == '0)   state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Mask decode for the upcoming state; live inputs matter only on accept
    always_comb begin
        sel_path   = (state == ST_IDLE) ? path_sel : path_q;
        sel_bit    = (state == ST_IDLE) ? bit_sel  : bit_q;
        a_ring_nxt = '0;
        a_ext_nxt  = '0;
        s_out_nxt  = '0;
        if (state_nxt inside {ST_SETUP, ST_SETTLE, ST_MEASURE}) begin
            case (sel_path)
                PATH_A_RING: a_ring_nxt = onehot32(sel_bit);
                PATH_A_EXT:  a_ext_nxt  = onehot32(sel_bit);
                PATH_S_OUT:  s_out_nxt  = onehot32(sel_bit);
                default:     ;
            endcase
        end
    end

    // Latched configuration and the settle / gate down-counters
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            gate_q     <= '0;
            path_q     <= '0;
            bit_q      <= '0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
        end else begin
            if (accept || reject) begin
                gate_q <= gate_len;
                path_q <= path_sel;
                bit_q  <= bit_sel;
            end
            if (state == ST_SETUP)
                settle_cnt <= ST_W'(SETTLE_CYCLES - 1);
            else if (state == ST_SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
            if (state == ST_SETTLE)
                gate_cnt <= gate_q - 1'b1;
            else if (state == ST_MEASURE && gate_cnt != '0)
                gate_cnt <= gate_cnt - 1'b1;
        end
    end

    // Registered outputs, derived from the next state so they change on transitions
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy        <= 1'b0;
            ring_en     <= 1'b0;
            done        <= 1'b0;
            a_ring_mask <= '0;
            a_ext_mask  <= '0;
            s_out_mask  <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            err         <= 1'b0;
        end else begin
            busy        <= (state_nxt != ST_IDLE);
            ring_en     <= (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE);
            done        <= (state_nxt == ST_DONE);
            a_ring_mask <= a_ring_nxt;
            a_ext_mask  <= a_ext_nxt;
            s_out_mask  <= s_out_nxt;
            if (accept || reject) begin
                count    <= '0;
                overflow <= 1'b0;
                err      <= reject;
            end else if (state == ST_MEASURE && rise) begin
                // Saturate; overflow flags an edge that could not be counted
                if (&count) overflow <= 1'b1;
                else        count    <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
